// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module   : aes_pkg
// Brief    : Shared AES state constants and the inverse-substitution FSM type.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

endpackage

`default_nettype wire

// File: rtl/inv_sbox.sv
//------------------------------------------------------------------------------
// Module   : inv_sbox
// Brief    : Combinational AES inverse S-box, full 256-entry lookup.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] c_inv_sbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_byte = c_inv_sbox[i_byte];

endmodule

`default_nettype wire

// File: rtl/inv_sub_bytes.sv
//------------------------------------------------------------------------------
// Module   : inv_sub_bytes
// Brief    : Iterative AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE
//            bytes per cycle, with valid/ready handshakes on both sides.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  aes_state_e             r_fsm;
  aes_state_e             w_fsm_nxt;
  logic [4:0]             r_cnt;
  logic [4:0]             w_cnt_nxt;
  logic [AES_STATE_W-1:0] r_state;
  logic [AES_STATE_W-1:0] w_state_nxt;
  logic                   w_capture;
  logic                   w_step;

  logic [3:0] w_pos    [BYTES_PER_CYCLE];
  logic [7:0] w_sb_in  [BYTES_PER_CYCLE];
  logic [7:0] w_sb_out [BYTES_PER_CYCLE];

  assign w_cnt_nxt = r_cnt + 5'(BYTES_PER_CYCLE);

  // Byte k lives at bits [8*(15-k) +: 8]; for a 4-bit k, 15-k is simply ~k.
  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    assign w_pos[g]   = 4'(r_cnt[3:0] + 4'(g));
    assign w_sb_in[g] = r_state[{~w_pos[g], 3'b000} +: 8];

    inv_sbox u_inv_sbox (
      .i_byte (w_sb_in[g]),
      .o_byte (w_sb_out[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      w_state_nxt[{~w_pos[i], 3'b000} +: 8] = w_sb_out[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_capture = 1'b0;
    w_step    = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (in_valid) begin
          w_capture = 1'b1;
          w_fsm_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_cnt_nxt == 5'(AES_BYTES)) begin
          w_fsm_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_state <= in_state;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign in_ready  = (r_fsm == ST_IDLE);
  assign out_valid = (r_fsm == ST_DONE);
  assign busy      = (r_fsm != ST_IDLE);
  assign out_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes.sv
//------------------------------------------------------------------------------
// Module   : tb_inv_sub_bytes
// Brief    : Self-checking bench for inv_sub_bytes at 1, 4 and 16 bytes/cycle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_inv_sub_bytes;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;
  logic         in_valid_1, in_ready_1, out_valid_1, busy_1;
  logic         in_valid_16, in_ready_16, out_valid_16, busy_16;
  logic [127:0] out_state_1, out_state_16;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  inv_sub_bytes #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy)
  );

  inv_sub_bytes #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_state(in_state), .out_valid(out_valid_1), .out_ready(1'b1),
    .out_state(out_state_1), .busy(busy_1)
  );

  inv_sub_bytes #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .in_state(in_state), .out_valid(out_valid_16), .out_ready(1'b1),
    .out_state(out_state_16), .busy(busy_16)
  );

  // Reference model: forward S-box from GF(2^8) inversion plus the affine map,
  // the inverse table obtained by inverting that mapping.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_calc(input logic [7:0] x);
    logic [7:0] b = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[s[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] ref_fwd(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = fwd_tab[s[127-8*k -: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered #1 after the capture edge; counts edges until out_valid.
  task automatic wait_done(input int exp_lat, input logic [127:0] exp, input string nm);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({nm, "_state"}, out_state, exp);
  endtask

  task automatic xfer(input logic [127:0] st, input logic [127:0] exp, input string nm);
    @(negedge clk);
    in_valid = 1'b1;
    in_state = st;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(4, exp, nm);
    @(posedge clk); #1;
    chk({nm, "_released"}, {126'd0, out_valid, in_ready}, 128'd1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s, s2, held;
    int lat1, lat16;
    bit seen;

    vecs[0] = '{{16{8'h63}}, {16{8'h00}}};
    vecs[1] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[2] = '{{16{8'h00}}, {16{8'h52}}};
    vecs[3] = '{{16{8'h16}}, {16{8'hff}}};
    vecs[4] = '{{4{32'h637c0016}}, {4{32'h000152ff}}};

    for (int x = 0; x < 256; x++) begin
      fwd_tab[x] = fwd_calc(8'(x));
      inv_tab[fwd_tab[x]] = 8'(x);
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
    in_valid_1 = 1'b0; in_valid_16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {125'd0, in_ready, out_valid, busy}, 128'd4);
    chk("reset_state", out_state, 128'd0);

    // Capture on the very first edge after reset release.
    @(negedge clk);
    in_valid = 1'b1;
    in_state = {16{8'h63}};
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_edge_capture", {127'd0, busy}, 128'd1);
    wait_done(4, {16{8'h00}}, "first_xfer");
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) xfer(vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      s = rnd128();
      xfer(s, ref_inv(s), $sformatf("rand%0d", i));
    end

    // Every byte value at every position must round-trip through the forward map.
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = 8'(v + k);
      @(negedge clk);
      in_valid = 1'b1;
      in_state = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(4, ref_inv(s), $sformatf("sweep%0d", v));
      chk($sformatf("sweep%0d_roundtrip", v), ref_fwd(out_state), s);
      @(posedge clk); #1;
    end

    // Back-pressure in DONE, then an output handshake with in_valid already high.
    s = rnd128();
    s2 = rnd128();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_state = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(4, ref_inv(s), "hold_load");
    held = ref_inv(s);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_state = rnd128();
      @(posedge clk); #1;
      chk($sformatf("hold%0d_flags", i), {126'd0, out_valid, in_ready}, 128'd2);
      chk($sformatf("hold%0d_state", i), out_state, held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_state = s2;
    @(posedge clk); #1;
    chk("done_to_idle", {125'd0, out_valid, in_ready, busy}, 128'd2);
    @(posedge clk); #1;
    chk("capture_after_idle", {127'd0, busy}, 128'd1);
    in_valid = 1'b0;
    wait_done(4, ref_inv(s2), "post_hold");
    @(posedge clk); #1;

    // Asynchronous reset during the second RUN cycle.
    @(negedge clk);
    in_valid = 1'b1;
    in_state = rnd128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
    chk("midrun_reset_state", out_state, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no_valid_after_reset", {127'd0, seen}, 128'd0);
    s = rnd128();
    xfer(s, ref_inv(s), "after_reset");

    // Latency at 1 and 16 bytes per cycle, same input to both.
    for (int t = 0; t < 2; t++) begin
      s = (t == 0) ? {16{8'h63}} : rnd128();
      lat1 = 0; lat16 = 0;
      @(negedge clk);
      in_state = s;
      in_valid_1 = 1'b1;
      in_valid_16 = 1'b1;
      @(posedge clk); #1;
      in_valid_1 = 1'b0;
      in_valid_16 = 1'b0;
      for (int e = 1; e <= 24; e++) begin
        @(posedge clk); #1;
        if (out_valid_1 && lat1 == 0) begin
          lat1 = e;
          chk($sformatf("bpc1_state%0d", t), out_state_1, ref_inv(s));
        end
        if (out_valid_16 && lat16 == 0) begin
          lat16 = e;
          chk($sformatf("bpc16_state%0d", t), out_state_16, ref_inv(s));
        end
      end
      chk($sformatf("bpc1_latency%0d", t), 128'(lat1), 128'd16);
      chk($sformatf("bpc16_latency%0d", t), 128'(lat16), 128'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
